// File: rtl/vec_result_writer.sv
// vec_result_writer
//   Writeback stage of the vector ALU. A whole vector result (LANES lanes of
//   LANE_W bits) plus one flag nibble per lane is captured in one cycle. It is
//   then written to a LANE_W-wide data memory one lane per accepted write,
//   skipping lanes whose mask bit is clear.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready vector handshake; in_ready is high only while idle
//   result            LANES*LANE_W vector data, lane i at [LANE_W*i +: LANE_W]
//   flags             LANES*4 flag nibbles, lane i at [4*i +: 4]
//   base_addr         word address of lane 0 (lane i goes to base_addr + i, wrapping)
//   lane_mask         1 = write lane i
//   mem_we/mem_ready  write request; the write is taken when both are high
//   mem_addr/mem_wdata write address and data, stable while mem_ready is low
//   done              one-cycle pulse after the last lane has been handled
//   flags_red         OR of the flag nibbles of the written lanes; valid with
//                     done and held until the next done
//   busy              inverse of in_ready
module vec_result_writer #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] result,
    input  logic [LANES*4-1:0]      flags,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LANES-1:0]        lane_mask,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANE_W-1:0]       mem_wdata,
    output logic                    done,
    output logic [3:0]              flags_red,
    output logic                    busy
);

    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [LANES-1:0][LANE_W-1:0]   data_q, data_d;
    logic [LANES-1:0][3:0]          flg_q, flg_d;
    logic [ADDR_W-1:0]              base_q, base_d;
    logic [LANES-1:0]               mask_q, mask_d;
    logic [LIDX_W-1:0]              lane_q, lane_d;
    logic [3:0]                     acc_q, acc_d;
    logic [3:0]                     flags_red_q, flags_red_d;

    logic       lane_on;
    logic       wr_req;
    logic       wr_take;
    logic       lane_adv;
    logic [3:0] acc_nxt;

    // Write request is a pure decode of registered state, so it can never
    // appear in IDLE or DONE and cannot glitch with the inputs.
    assign lane_on  = mask_q[lane_q];
    assign wr_req   = (state_q == WRITE) && lane_on;
    assign wr_take  = wr_req && mem_ready;
    // Masked-off lanes still take one cycle; they just do not request a write.
    assign lane_adv = (state_q == WRITE) && (wr_take || !lane_on);
    // Include the lane being accepted this cycle so the final lane's nibble
    // lands in flags_red on the same edge that enters DONE.
    assign acc_nxt  = acc_q | (wr_take ? flg_q[lane_q] : 4'h0);

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        flg_d       = flg_q;
        base_d      = base_q;
        mask_d      = mask_q;
        lane_d      = lane_q;
        acc_d       = acc_q;
        flags_red_d = flags_red_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d = result;
                    flg_d  = flags;
                    base_d = base_addr;
                    mask_d = lane_mask;
                    lane_d = '0;
                    acc_d  = 4'h0;
                    if (|lane_mask) begin
                        state_d = WRITE;
                    end else begin
                        // Nothing to write: report an empty vector right away.
                        state_d     = DONE;
                        flags_red_d = 4'h0;
                    end
                end
            end
            WRITE: begin
                acc_d = acc_nxt;
                if (lane_adv) begin
                    if (lane_q == LAST_LANE) begin
                        state_d     = DONE;
                        flags_red_d = acc_nxt;
                        acc_d       = 4'h0;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            flg_q       <= '0;
            base_q      <= '0;
            mask_q      <= '0;
            lane_q      <= '0;
            acc_q       <= 4'h0;
            flags_red_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            flg_q       <= flg_d;
            base_q      <= base_d;
            mask_q      <= mask_d;
            lane_q      <= lane_d;
            acc_q       <= acc_d;
            flags_red_q <= flags_red_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = ~in_ready;
    assign done      = (state_q == DONE);
    assign flags_red = flags_red_q;
    assign mem_we    = wr_req;
    // Address wraps naturally in ADDR_W bits.
    assign mem_addr  = (state_q == WRITE) ? (base_q + ADDR_W'(lane_q)) : '0;
    assign mem_wdata = (state_q == WRITE) ? data_q[lane_q] : '0;

endmodule
